// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state type, lane constants and address limit for the memory access master
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam int unsigned ADDR_LIMIT_DEFAULT = 512;

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - byte lane extract (zero/sign extend) for loads and lane merge for byte stores
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [15:0] i_word,
  input  logic        i_lane,
  input  logic        i_signed,
  input  logic [7:0]  i_wbyte,
  output logic [15:0] o_load,
  output logic [15:0] o_merged
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte   = (i_lane == LANE_HI) ? i_word[15:8] : i_word[7:0];
    o_load   = {{8{i_signed & w_byte[7]}}, w_byte};
    o_merged = (i_lane == LANE_LO) ? {i_word[15:8], i_wbyte} : {i_wbyte, i_word[7:0]};
  end

endmodule

// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - single-outstanding load/store controller for the 256 x 16 word memory
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_address,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [15:0] mem_read_data
);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_byte;
  logic        r_signed;
  logic        r_lane;
  logic [7:0]  r_wbyte;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [15:0] r_mem_address;
  logic [15:0] r_mem_data;
  logic        w_accept;
  logic        w_err;
  logic [15:0] w_load;
  logic [15:0] w_merged;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_err    = ({16'd0, req_address} >= 32'(ADDR_LIMIT)) || (!req_byte && req_address[0]);

  byte_lane_unit u_lane (
    .i_word   (mem_read_data),
    .i_lane   (r_lane),
    .i_signed (r_signed),
    .i_wbyte  (r_wbyte),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Strobes, ready and valid decode straight from the state so reset drops them at once.
  always_comb begin
    w_next           = r_state;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                      w_next = RESP;
          else if (req_write && !req_byte) w_next = WRITE;
          else                             w_next = READ;
        end
      end
      READ: begin
        mem_read_enable = 1'b1;
        w_next          = r_write ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        w_next           = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write       <= 1'b0;
      r_byte        <= 1'b0;
      r_signed      <= 1'b0;
      r_lane        <= 1'b0;
      r_wbyte       <= 8'd0;
      r_rsp_rdata   <= 16'd0;
      r_rsp_error   <= 1'b0;
      r_mem_address <= 16'd0;
      r_mem_data    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_write     <= req_write;
        r_byte      <= req_byte;
        r_signed    <= req_signed;
        r_lane      <= req_address[0];
        r_wbyte     <= req_wdata[7:0];
        r_rsp_error <= w_err;
        r_rsp_rdata <= 16'd0;
        if (!w_err) begin
          r_mem_address <= {req_address[15:1], 1'b0};
          if (req_write && !req_byte) r_mem_data <= req_wdata;
        end
      end
      // Read data is consumed on the READ edge: either the load result or the merged store word.
      if (r_state == READ) begin
        if (r_write)     r_mem_data  <= w_merged;
        else if (r_byte) r_rsp_rdata <= w_load;
        else             r_rsp_rdata <= mem_read_data;
      end
    end
  end

  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;

endmodule

// File: tb/tb_mem_access_master.sv
// tb/tb_mem_access_master.sv - self-checking bench for mem_access_master against a word-array reference model
module tb_mem_access_master;

  localparam int LIMIT = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_address = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [15:0] mem_read_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem     [256];
  logic [15:0] pl_img  [256];
  logic [15:0] ref_mem [256];
  logic        pl_en = 1'b0;

  always #5 clk = ~clk;

  mem_access_master #(.ADDR_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_byte         (req_byte),
    .req_signed       (req_signed),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[8:1]];

  always @(posedge clk) begin
    if (pl_en)                 mem <= pl_img;
    else if (mem_write_enable) mem[mem_address[8:1]] <= mem_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_mem_we"}, mem_write_enable, 0);
    check({tag, "_mem_re"}, mem_read_enable, 0);
  endtask

  // Called at a negedge with the controller idle; returns at a negedge with it idle again.
  task automatic do_req(input logic w, input logic b, input logic s, input logic [15:0] a,
                        input logic [15:0] wd, input int hold, input logic hold_valid,
                        output logic [15:0] got_rdata, output logic [15:0] got_wdata,
                        output logic got_err);
    logic        err;
    logic        seen;
    logic [15:0] word, new_word, exp_rdata, ea;
    logic [7:0]  lane_byte;
    int          lat, exp_rd, exp_wr, rd_cnt, wr_cnt, n, waited;

    err       = (a >= LIMIT) || (!b && a[0]);
    ea        = {a[15:1], 1'b0};
    word      = ref_mem[a[8:1]];
    lane_byte = a[0] ? word[15:8] : word[7:0];
    exp_rdata = 16'd0;
    new_word  = word;
    if (!err && !w) begin
      if (!b)                          exp_rdata = word;
      else if (s && lane_byte >= 128)  exp_rdata = 16'hFF00 + 16'(lane_byte);
      else                             exp_rdata = 16'(lane_byte);
    end
    if (!err && w) begin
      if (!b)       new_word = wd;
      else if (a[0]) new_word = (word & 16'h00FF) | (16'(wd[7:0]) << 8);
      else           new_word = (word & 16'hFF00) | 16'(wd[7:0]);
    end
    lat    = err ? 1 : ((w && b) ? 3 : 2);
    exp_rd = (!err && (!w || b)) ? 1 : 0;
    exp_wr = (!err && w) ? 1 : 0;
    got_rdata = 16'd0;
    got_wdata = 16'd0;
    got_err   = 1'b0;

    req_valid   = 1'b1;
    req_write   = w;
    req_byte    = b;
    req_signed  = s;
    req_address = a;
    req_wdata   = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", waited, 0);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    n = 0; seen = 1'b0; rd_cnt = 0; wr_cnt = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      check("req_ready_busy", req_ready, 0);
      if (mem_read_enable) begin
        rd_cnt++;
        check("rd_addr", mem_address, ea);
      end
      if (mem_write_enable) begin
        wr_cnt++;
        check("wr_addr", mem_address, ea);
        check("wr_data", mem_data, new_word);
        got_wdata = mem_data;
      end
      if (rsp_valid) seen = 1'b1;
    end
    check("rsp_latency", n, lat);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_error", rsp_error, err);
    check("read_strobes", rd_cnt, exp_rd);
    check("write_strobes", wr_cnt, exp_wr);
    got_rdata = rsp_rdata;
    got_err   = rsp_error;

    for (int i = 0; i < hold; i++) begin
      if (hold_valid) req_valid = 1'b1;
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, exp_rdata);
      check("hold_rsp_error", rsp_error, err);
      check("hold_req_ready", req_ready, 0);
      check("hold_strobes", {mem_read_enable, mem_write_enable}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    if (!err && w) begin
      check("mem_commit", mem[a[8:1]], new_word);
      ref_mem[a[8:1]] = new_word;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, wdv;
    logic        er;
    logic        w, b, s;
    logic [15:0] a, wd;

    for (int i = 0; i < 256; i++) pl_img[i] = 16'($urandom);
    pl_img[8'h09] = 16'h80FF;
    pl_img[8'h10] = 16'h1234;
    for (int i = 0; i < 256; i++) ref_mem[i] = pl_img[i];

    pl_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pl_en = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 0, 1'b0, rd, wdv, er);
    check("lit_word_store_data", wdv, 16'hBEEF);
    do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_word_load", rd, 16'hBEEF);

    do_req(1'b0, 1'b1, 1'b1, 16'h0013, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_byte_load_signed", rd, 16'hFF80);
    do_req(1'b0, 1'b1, 1'b0, 16'h0013, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_byte_load_unsigned", rd, 16'h0080);

    do_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h00AB, 0, 1'b0, rd, wdv, er);
    check("lit_byte_store_merge", wdv, 16'hAB34);

    do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_misaligned_err", {er, rd}, {1'b1, 16'h0000});
    do_req(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_limit_err_load", {er, rd}, {1'b1, 16'h0000});
    do_req(1'b1, 1'b0, 1'b0, 16'h0200, 16'h1111, 0, 1'b0, rd, wdv, er);
    check("lit_limit_err_store", er, 1);
    do_req(1'b0, 1'b0, 1'b0, 16'h01FE, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_last_word_ok", er, 0);

    do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 5, 1'b1, rd, wdv, er);
    do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 1'b0, rd, wdv, er);
    check("lit_after_stall", rd, 16'hAB34);

    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_byte    = 1'b1;
    req_signed  = 1'b0;
    req_address = 16'h0041;
    req_wdata   = 16'h005A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_read_phase", mem_read_enable, 1);
    @(negedge clk);
    check("rst_mid_write_phase", mem_write_enable, 1);
    reset = 1'b1;
    #1;
    check("rst_async_we_drop", mem_write_enable, 0);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    check("rst_no_commit", mem[8'h20], ref_mem[8'h20]);

    for (int k = 0; k < 80; k++) begin
      w  = 1'($urandom);
      b  = 1'($urandom);
      s  = 1'($urandom);
      wd = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 31));
      else a = 16'($urandom_range(0, LIMIT - 1));
      do_req(w, b, s, a, wd, $urandom_range(0, 3), 1'($urandom), rd, wdv, er);
    end
    req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
